snake_move_scheduler: RTL and testbench

SNAKE_MOVE_SCHEDULER -- requirements
Module: snake_move_scheduler

---
 rtl/snake_move_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_snake_move_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_move_scheduler.sv
// Move scheduler for the snake game: queues direction presses, and on each game
// tick probes the next head cell, then commits the move, grows, or reports a collision.
module snake_move_scheduler (
    input  logic       board_clk,
    input  logic       Reset,
    input  logic       tick_en,
    input  logic       run,
    input  logic       dir_valid,
    input  logic [1:0] dir_in,
    input  logic [3:0] head_x,
    input  logic [3:0] head_y,
    input  logic [3:0] tail_x,
    input  logic [3:0] tail_y,
    input  logic [3:0] apple_x,
    input  logic [3:0] apple_y,
    input  logic       occ_hit,
    input  logic       apple_ack,
    output logic       probe_req,
    output logic [3:0] probe_x,
    output logic [3:0] probe_y,
    output logic       move_go,
    output logic       grow,
    output logic       collision,
    output logic       apple_req,
    output logic [1:0] cur_dir,
    output logic       busy,
    output logic [2:0] fsm_state
);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_PROBE  = 3'd2,
        S_WAIT   = 3'd3,
        S_COMMIT = 3'd4,
        S_APPLE  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t     state, state_n;
    logic [1:0] fifo_q0, fifo_q1;
    logic [1:0] fifo_cnt;
    logic       hit_r, eat_r;

    logic       flush, load_probe, sample_occ;
    logic       push_en, pop_en, dup, reversal;
    logic [1:0] last_q, move_dir;
    logic [3:0] next_x, next_y;
    logic       wall, eat_c, tail_match;

    // A press is a duplicate of the most recent queued entry, or of the committed
    // direction when nothing is queued.
    assign last_q   = (fifo_cnt == 2'd2) ? fifo_q1 : fifo_q0;
    assign dup      = (fifo_cnt == 2'd0) ? (dir_in == cur_dir) : (dir_in == last_q);
    assign push_en  = dir_valid && run && (fifo_cnt != 2'd2) && !dup;
    assign pop_en   = load_probe && (fifo_cnt != 2'd0);

    assign reversal = (fifo_q0[1] == cur_dir[1]) && (fifo_q0[0] != cur_dir[0]);
    assign move_dir = ((fifo_cnt != 2'd0) && !reversal) ? fifo_q0 : cur_dir;

    always_comb begin
        next_x = head_x;
        next_y = head_y;
        wall   = 1'b0;
        case (move_dir)
            DIR_UP: begin
                next_y = head_y - 4'd1;
                wall   = (head_y == 4'd0);
            end
            DIR_DOWN: begin
                next_y = head_y + 4'd1;
                wall   = (head_y == 4'd14);
            end
            DIR_LEFT: begin
                next_x = head_x - 4'd1;
                wall   = (head_x == 4'd0);
            end
            default: begin
                next_x = head_x + 4'd1;
                wall   = (head_x == 4'd14);
            end
        endcase
    end

    // Entering the cell the tail is leaving is legal unless the tail stays put (eating).
    assign eat_c      = (probe_x == apple_x) && (probe_y == apple_y);
    assign tail_match = (probe_x == tail_x) && (probe_y == tail_y);

    // apple_req/apple_ack: apple_req is a level held from entry into APPLE through the
    // cycle that samples apple_ack=1; acks seen in any other state are ignored.
    always_comb begin
        state_n    = state;
        probe_req  = 1'b0;
        move_go    = 1'b0;
        grow       = 1'b0;
        collision  = 1'b0;
        apple_req  = 1'b0;
        flush      = 1'b0;
        load_probe = 1'b0;
        sample_occ = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick_en && run) state_n = S_POP;
            end
            S_POP: begin
                if (!run) begin
                    flush   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    load_probe = 1'b1;
                    state_n    = wall ? S_COMMIT : S_PROBE;
                end
            end
            S_PROBE: begin
                if (!run) begin
                    flush   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    probe_req = 1'b1;
                    state_n   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!run) begin
                    flush   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    sample_occ = 1'b1;
                    state_n    = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (!run) begin
                    flush   = 1'b1;
                    state_n = S_IDLE;
                end else if (hit_r) begin
                    collision = 1'b1;
                    state_n   = S_HALT;
                end else begin
                    move_go = 1'b1;
                    grow    = eat_r;
                    state_n = eat_r ? S_APPLE : S_IDLE;
                end
            end
            S_APPLE: begin
                apple_req = 1'b1;
                if (apple_ack) state_n = S_IDLE;
            end
            S_HALT: begin
                if (!run) begin
                    flush   = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            fifo_q0  <= 2'b00;
            fifo_q1  <= 2'b00;
            fifo_cnt <= 2'd0;
            cur_dir  <= DIR_RIGHT;
            probe_x  <= 4'd0;
            probe_y  <= 4'd0;
            hit_r    <= 1'b0;
            eat_r    <= 1'b0;
        end else begin
            if (flush) begin
                fifo_cnt <= 2'd0;
            end else begin
                case ({push_en, pop_en})
                    2'b10: begin
                        if (fifo_cnt == 2'd0) fifo_q0 <= dir_in;
                        else                  fifo_q1 <= dir_in;
                        fifo_cnt <= fifo_cnt + 2'd1;
                    end
                    2'b01: begin
                        fifo_q0  <= fifo_q1;
                        fifo_cnt <= fifo_cnt - 2'd1;
                    end
                    // Only reachable with one entry: the new press replaces the popped one.
                    2'b11: fifo_q0 <= dir_in;
                    default: ;
                endcase
            end

            if (flush)           cur_dir <= DIR_RIGHT;
            else if (load_probe) cur_dir <= move_dir;

            if (load_probe) begin
                probe_x <= next_x;
                probe_y <= next_y;
                hit_r   <= wall;
                eat_r   <= 1'b0;
            end else if (sample_occ) begin
                eat_r <= eat_c;
                hit_r <= occ_hit && !(tail_match && !eat_c);
            end
        end
    end

    assign busy      = (state != S_IDLE) && (state != S_HALT);
    assign fsm_state = state;

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Randomized bench for snake_move_scheduler against a queue-based model of the
// direction buffer and a grid-arithmetic model of each move.
module tb_snake_move_scheduler;

    logic       board_clk = 1'b0;
    logic       Reset, tick_en, run, dir_valid, occ_hit, apple_ack;
    logic [1:0] dir_in;
    logic [3:0] head_x, head_y, tail_x, tail_y, apple_x, apple_y;
    logic       probe_req, move_go, grow, collision, apple_req, busy;
    logic [3:0] probe_x, probe_y;
    logic [1:0] cur_dir;
    logic [2:0] fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] m_q[$];
    logic [1:0] m_cur;

    snake_move_scheduler dut (
        .board_clk(board_clk), .Reset(Reset), .tick_en(tick_en), .run(run),
        .dir_valid(dir_valid), .dir_in(dir_in),
        .head_x(head_x), .head_y(head_y), .tail_x(tail_x), .tail_y(tail_y),
        .apple_x(apple_x), .apple_y(apple_y), .occ_hit(occ_hit), .apple_ack(apple_ack),
        .probe_req(probe_req), .probe_x(probe_x), .probe_y(probe_y),
        .move_go(move_go), .grow(grow), .collision(collision), .apple_req(apple_req),
        .cur_dir(cur_dir), .busy(busy), .fsm_state(fsm_state)
    );

    always #5 board_clk = ~board_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Directions: 0 up, 1 down, 2 left, 3 right.
    function automatic logic [1:0] opposite(input logic [1:0] d);
        case (d)
            2'd0: return 2'd1;
            2'd1: return 2'd0;
            2'd2: return 2'd3;
            default: return 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] model_peek_dir();
        if (m_q.size() == 0) return m_cur;
        if (m_q[0] == opposite(m_cur)) return m_cur;
        return m_q[0];
    endfunction

    function automatic void model_pop();
        logic [1:0] d;
        d = model_peek_dir();
        if (m_q.size() > 0) m_q.delete(0);
        m_cur = d;
    endfunction

    function automatic bit model_accepts(input logic [1:0] d);
        if (!run) return 1'b0;
        if (m_q.size() >= 2) return 1'b0;
        if (m_q.size() > 0) return d != m_q[m_q.size() - 1];
        return d != m_cur;
    endfunction

    function automatic void model_flush();
        m_q.delete();
        m_cur = 2'd3;
    endfunction

    task automatic next_cell(input logic [1:0] d, input int hx, input int hy, output int nx, output int ny);
        nx = hx;
        ny = hy;
        case (d)
            2'd0: ny = hy - 1;
            2'd1: ny = hy + 1;
            2'd2: nx = hx - 1;
            default: nx = hx + 1;
        endcase
    endtask

    task automatic press(input logic [1:0] d);
        @(posedge board_clk); #1;
        dir_valid = 1'b1;
        dir_in    = d;
        if (model_accepts(d)) m_q.push_back(d);
        @(posedge board_clk); #1;
        dir_valid = 1'b0;
    endtask

    // One tick-driven move; cycle k counts from the tick cycle (k=0).
    task automatic do_move(input int hx, input int hy, input int tx, input int ty,
                           input int ax, input int ay, input bit occ, input int abort_in,
                           input bit mid_press, input logic [1:0] mid_dir, input int ack_delay);
        logic [1:0] d;
        int nx, ny, abort_at, ack_k, max_k;
        int n_probe, n_move, n_coll, n_overlap, k_probe, k_move, k_coll;
        bit wall, eat, hit, acc, grow_seen, exp_ar;
        logic [3:0] px, py;
        d = model_peek_dir();
        next_cell(d, hx, hy, nx, ny);
        wall = (nx < 0) || (nx > 14) || (ny < 0) || (ny > 14);
        eat  = !wall && (nx == ax) && (ny == ay);
        hit  = wall || (occ && !((nx == tx) && (ny == ty) && !eat));
        abort_at = wall ? 0 : abort_in;
        n_probe = 0; n_move = 0; n_coll = 0; n_overlap = 0;
        k_probe = -1; k_move = -1; k_coll = -1;
        grow_seen = 1'b0; px = 4'd0; py = 4'd0;
        ack_k = 5 + ack_delay;
        max_k = 8 + ack_delay;

        @(posedge board_clk); #1;
        head_x = 4'(hx); head_y = 4'(hy);
        tail_x = 4'(tx); tail_y = 4'(ty);
        apple_x = 4'(ax); apple_y = 4'(ay);
        occ_hit = occ;
        tick_en = 1'b1;
        for (int k = 1; k <= max_k; k++) begin
            @(posedge board_clk); #1;
            tick_en   = 1'b0;
            dir_valid = mid_press && (k == 1);
            dir_in    = mid_dir;
            run       = (k != abort_at);
            apple_ack = (k == ack_k) || (k == 3);
            if (k == 1) begin
                acc = mid_press && model_accepts(mid_dir);
                model_pop();
                if (acc) m_q.push_back(mid_dir);
            end
            if (k == abort_at) model_flush();
            @(negedge board_clk);
            if (probe_req) begin
                n_probe++;
                if (k_probe < 0) begin k_probe = k; px = probe_x; py = probe_y; end
            end
            if (move_go) begin
                n_move++;
                if (k_move < 0) begin k_move = k; grow_seen = grow; end
            end
            if (collision) begin
                n_coll++;
                if (k_coll < 0) k_coll = k;
            end
            if (int'(probe_req) + int'(move_go) + int'(collision) > 1) n_overlap++;
            exp_ar = eat && !hit && (abort_at == 0) && (k >= 5) && (k <= ack_k);
            check_eq("apple_req", apple_req, exp_ar);
            if (k <= 2) check_eq("busy_active", busy, 1);
        end
        @(posedge board_clk); #1;
        apple_ack = 1'b0;
        dir_valid = 1'b0;
        run       = 1'b1;

        check_eq("pulse_overlap", n_overlap, 0);
        if (abort_at != 0) begin
            check_eq("abort_move_go", n_move, 0);
            check_eq("abort_collision", n_coll, 0);
        end else if (wall) begin
            check_eq("wall_probe", n_probe, 0);
            check_eq("wall_collision", n_coll, 1);
            check_eq("wall_move_go", n_move, 0);
        end else begin
            check_eq("probe_count", n_probe, 1);
            check_eq("probe_cycle", k_probe, 2);
            check_eq("probe_x", px, nx);
            check_eq("probe_y", py, ny);
            if (hit) begin
                check_eq("collision_cycle", k_coll, 4);
                check_eq("hit_move_go", n_move, 0);
            end else begin
                check_eq("move_go_cycle", k_move, 4);
                check_eq("move_go_count", n_move, 1);
                check_eq("grow", grow_seen, eat);
                check_eq("free_collision", n_coll, 0);
            end
        end
        check_eq("busy_done", busy, 0);
        check_eq("cur_dir", cur_dir, m_cur);

        if (hit && abort_at == 0) begin
            run = 1'b0;
            model_flush();
            @(posedge board_clk); #1;
            run = 1'b1;
            @(negedge board_clk);
            check_eq("halt_release_dir", cur_dir, m_cur);
            check_eq("halt_release_busy", busy, 0);
        end
    endtask

    task automatic random_move();
        logic [1:0] d;
        int hx, hy, nx, ny, tx, ty, ax, ay, c, abort_at;
        bit occ, mp;
        for (int p = int'($urandom_range(0, 3)); p > 0; p--) press(2'($urandom_range(0, 3)));
        d  = model_peek_dir();
        hx = int'($urandom_range(0, 14));
        hy = int'($urandom_range(0, 14));
        if ($urandom_range(0, 4) == 0) begin
            case (d)
                2'd0: hy = 0;
                2'd1: hy = 14;
                2'd2: hx = 0;
                default: hx = 14;
            endcase
        end
        next_cell(d, hx, hy, nx, ny);
        tx = int'($urandom_range(0, 14)); ty = int'($urandom_range(0, 14));
        ax = int'($urandom_range(0, 14)); ay = int'($urandom_range(0, 14));
        c  = int'($urandom_range(0, 3));
        if (c == 0 || c == 2) begin ax = nx; ay = ny; end
        if (c == 1 || c == 2) begin tx = nx; ty = ny; end
        occ = 1'($urandom_range(0, 1));
        abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 4)) : 0;
        mp = ($urandom_range(0, 3) == 0);
        do_move(hx, hy, tx, ty, ax, ay, occ, abort_at, mp, 2'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)));
    endtask

    task automatic reset_in_apple();
        logic [1:0] d;
        int nx, ny;
        bit seen;
        d = model_peek_dir();
        next_cell(d, 7, 7, nx, ny);
        @(posedge board_clk); #1;
        head_x = 4'd7; head_y = 4'd7; tail_x = 4'd0; tail_y = 4'd0;
        apple_x = 4'(nx); apple_y = 4'(ny); occ_hit = 1'b0;
        tick_en = 1'b1;
        model_pop();
        seen = 1'b0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            @(posedge board_clk); #1;
            tick_en = 1'b0;
            @(negedge board_clk);
            seen = apple_req;
        end
        check_eq("apple_wait", seen, 1);
        @(posedge board_clk); #1;
        Reset = 1'b1;
        #1;
        check_eq("reset_apple_req", apple_req, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_cur_dir", cur_dir, 3);
        model_flush();
        @(posedge board_clk); #1;
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            apple_ack = 1'b1;
            @(negedge board_clk);
            check_eq("post_reset_apple_req", apple_req, 0);
            @(posedge board_clk); #1;
            apple_ack = 1'b0;
        end
    endtask

    initial begin
        Reset = 1'b1; tick_en = 1'b0; run = 1'b0; dir_valid = 1'b0; dir_in = 2'd0;
        head_x = 4'd0; head_y = 4'd0; tail_x = 4'd0; tail_y = 4'd0;
        apple_x = 4'd0; apple_y = 4'd0; occ_hit = 1'b0; apple_ack = 1'b0;
        model_flush();
        repeat (3) @(posedge board_clk);
        @(negedge board_clk);
        check_eq("rst_probe_req", probe_req, 0);
        check_eq("rst_probe_x", probe_x, 0);
        check_eq("rst_probe_y", probe_y, 0);
        check_eq("rst_move_go", move_go, 0);
        check_eq("rst_grow", grow, 0);
        check_eq("rst_collision", collision, 0);
        check_eq("rst_apple_req", apple_req, 0);
        check_eq("rst_cur_dir", cur_dir, 3);
        check_eq("rst_busy", busy, 0);
        @(posedge board_clk); #1;
        Reset = 1'b0;
        run   = 1'b1;

        // Straight move right from (7,7).
        do_move(7, 7, 6, 7, 0, 0, 1'b0, 0, 1'b0, 2'd0, 0);
        // Left is a reversal of right and is discarded; up then takes effect.
        press(2'd2);
        press(2'd0);
        do_move(7, 7, 6, 7, 0, 0, 1'b0, 0, 1'b0, 2'd0, 0);
        do_move(8, 7, 8, 8, 0, 0, 1'b0, 0, 1'b0, 2'd0, 0);
        check_eq("fifo_drained", m_q.size(), 0);
        // Eat with the ack three cycles into the handshake.
        press(2'd3);
        do_move(3, 5, 2, 5, 4, 5, 1'b0, 0, 1'b0, 2'd0, 3);
        // Right wall.
        do_move(14, 2, 13, 2, 0, 0, 1'b0, 0, 1'b0, 2'd0, 0);
        // Chasing the tail is legal unless the apple sits there.
        do_move(4, 5, 5, 5, 9, 9, 1'b1, 0, 1'b0, 2'd0, 0);
        do_move(4, 5, 5, 5, 5, 5, 1'b1, 0, 1'b0, 2'd0, 0);
        // Third distinct press overflows.
        press(2'd0);
        press(2'd1);
        press(2'd2);
        check_eq("overflow_model", m_q.size(), 2);
        do_move(7, 7, 7, 8, 0, 0, 1'b0, 0, 1'b0, 2'd0, 0);
        do_move(7, 6, 7, 7, 0, 0, 1'b0, 0, 1'b0, 2'd0, 0);
        // Aborts in PROBE, WAIT and COMMIT.
        for (int a = 2; a <= 4; a++) begin
            press(2'd1);
            do_move(7, 7, 0, 0, 0, 0, 1'b0, a, 1'b0, 2'd0, 0);
            do_move(7, 7, 0, 0, 0, 0, 1'b0, 0, 1'b0, 2'd0, 0);
        end
        // Press landing in the same cycle as the pop.
        press(2'd0);
        do_move(7, 7, 0, 0, 0, 0, 1'b0, 0, 1'b1, 2'd2, 0);
        do_move(7, 7, 0, 0, 0, 0, 1'b0, 0, 1'b0, 2'd0, 0);
        // Presses while not running are dropped.
        run = 1'b0;
        press(2'd1);
        run = 1'b1;
        do_move(7, 7, 0, 0, 0, 0, 1'b0, 0, 1'b0, 2'd0, 0);

        for (int i = 0; i < 150; i++) random_move();

        reset_in_apple();
        do_move(7, 7, 0, 0, 0, 0, 1'b0, 0, 1'b0, 2'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
